nios2_pio_in_edge: RTL and testbench

Parametrised Avalon-MM input-port slave for the Nios II system: samples a WIDTH-bit external input through a synchroniser, exposes the level on a data register, latches selected edges into a sticky edge-capture register and raises a maskable level interrupt. It replaces fixed-width, data-only input ports on the system interconnect, for example scanner or button inputs.

---
 rtl/nios2_pio_in_edge_if.sv | 25 ++
 rtl/nios2_pio_in_edge.sv | 91 +++++++++
 tb/tb_nios2_pio_in_edge.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/nios2_pio_in_edge_if.sv
// Avalon-MM slave bus bundle for the edge-capturing input port.
// The master drives address/strobes/write data; the slave returns registered read data.
interface nios2_pio_in_edge_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/nios2_pio_in_edge.sv
// Avalon-MM input port: synchronised level register, sticky edge capture with
// write-1-to-clear, interrupt mask and a level interrupt.
module nios2_pio_in_edge #(
    parameter int WIDTH       = 8,
    parameter int EDGE_TYPE   = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    nios2_pio_in_edge_if.slave   bus,
    input  logic [WIDTH-1:0]     in_port,
    output logic                 irq
);

    localparam logic [1:0] EDGE_SEL = EDGE_TYPE[1:0];

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] edgecap_q, edgecap_d;
    logic [31:0]      readdata_q, readdata_d;

    logic [WIDTH-1:0] level_s;
    logic [WIDTH-1:0] detect_s;
    logic [WIDTH-1:0] clr_s;
    logic             wr_s;

    function automatic logic [31:0] zext(input logic [WIDTH-1:0] v);
        logic [31:0] r;
        r = 32'd0;
        r[WIDTH-1:0] = v;
        return r;
    endfunction

    // Next-state logic: synchroniser shift, edge detect, register writes, read mux.
    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], in_port};
        level_s = sync_q[SYNC_STAGES-1];
        prev_d  = level_s;

        case (EDGE_SEL)
            2'd0:    detect_s = level_s & ~prev_q;
            2'd1:    detect_s = ~level_s & prev_q;
            default: detect_s = level_s ^ prev_q;
        endcase

        wr_s   = bus.chipselect & ~bus.write_n;
        mask_d = mask_q;
        clr_s  = {WIDTH{1'b0}};
        if (wr_s) begin
            case (bus.address)
                2'd2:    mask_d = bus.writedata[WIDTH-1:0];
                2'd3:    clr_s  = bus.writedata[WIDTH-1:0];
                default: mask_d = mask_q;
            endcase
        end else begin
            mask_d = mask_q;
        end

        // A new edge in the same cycle as its clear keeps the bit set.
        edgecap_d = (edgecap_q & ~clr_s) | detect_s;

        case (bus.address)
            2'd0:    readdata_d = zext(level_s);
            2'd2:    readdata_d = zext(mask_q);
            2'd3:    readdata_d = zext(edgecap_q);
            default: readdata_d = 32'd0;
        endcase
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q     <= {(SYNC_STAGES*WIDTH){1'b0}};
            prev_q     <= {WIDTH{1'b0}};
            mask_q     <= {WIDTH{1'b0}};
            edgecap_q  <= {WIDTH{1'b0}};
            readdata_q <= 32'd0;
        end else begin
            sync_q     <= sync_d;
            prev_q     <= prev_d;
            mask_q     <= mask_d;
            edgecap_q  <= edgecap_d;
            readdata_q <= readdata_d;
        end
    end

    assign bus.readdata = readdata_q;
    assign irq          = |(edgecap_q & mask_q);

endmodule

// File: tb/tb_nios2_pio_in_edge.sv
// Scoreboard bench for nios2_pio_in_edge: three configurations share one bus and
// input stream and are checked against a history-based reference model.
module tb_nios2_pio_in_edge;

    typedef struct packed {
        logic [2:0]       irq;
        logic [2:0][31:0] rd;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] in_port;

    logic [2:0]  irq_a;
    logic [31:0] rd_a [3];

    int checks = 0;
    int errors = 0;

    exp_t        exp_q[$];
    logic [31:0] samp[$];
    logic [31:0] m_cap [3];
    logic [31:0] m_mask[3];

    always #5 clk = ~clk;

    nios2_pio_in_edge_if bus0();
    nios2_pio_in_edge_if bus1();
    nios2_pio_in_edge_if bus2();

    assign bus0.address = address;  assign bus0.chipselect = chipselect;
    assign bus0.write_n = write_n;  assign bus0.writedata  = writedata;
    assign bus1.address = address;  assign bus1.chipselect = chipselect;
    assign bus1.write_n = write_n;  assign bus1.writedata  = writedata;
    assign bus2.address = address;  assign bus2.chipselect = chipselect;
    assign bus2.write_n = write_n;  assign bus2.writedata  = writedata;

    nios2_pio_in_edge #(.WIDTH(8), .EDGE_TYPE(0), .SYNC_STAGES(2)) dut0 (
        .clk(clk), .reset_n(reset_n), .bus(bus0), .in_port(in_port[7:0]), .irq(irq_a[0]));
    nios2_pio_in_edge #(.WIDTH(32), .EDGE_TYPE(1), .SYNC_STAGES(3)) dut1 (
        .clk(clk), .reset_n(reset_n), .bus(bus1), .in_port(in_port), .irq(irq_a[1]));
    nios2_pio_in_edge #(.WIDTH(32), .EDGE_TYPE(2), .SYNC_STAGES(4)) dut2 (
        .clk(clk), .reset_n(reset_n), .bus(bus2), .in_port(in_port), .irq(irq_a[2]));

    assign rd_a[0] = bus0.readdata;
    assign rd_a[1] = bus1.readdata;
    assign rd_a[2] = bus2.readdata;

    function automatic int sdepth(input int d);
        case (d)
            0:       return 2;
            1:       return 3;
            default: return 4;
        endcase
    endfunction

    function automatic int etype(input int d);
        case (d)
            0:       return 0;
            1:       return 1;
            default: return 2;
        endcase
    endfunction

    function automatic logic [31:0] wmask(input int d);
        return (d == 0) ? 32'h0000_00FF : 32'hFFFF_FFFF;
    endfunction

    // Level visible after edge m: the input sampled S edges earlier (0 before that).
    function automatic logic [31:0] lvl(input int d, input int m);
        if (m >= sdepth(d)) return samp[m - sdepth(d)] & wmask(d);
        return 32'd0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, expv, $time);
        end
    endtask

    // Reference model: evaluates each clock edge from the input history and bus activity.
    always @(posedge clk) begin : model
        exp_t        e;
        int          n;
        logic [31:0] l1, l0, det, clr, w;
        logic        wr_s;
        e = '0;
        if (!reset_n) begin
            samp.delete();
            for (int d = 0; d < 3; d++) begin
                m_cap[d]  = 32'd0;
                m_mask[d] = 32'd0;
            end
        end else begin
            samp.push_back(in_port);
            n    = samp.size();
            wr_s = chipselect && !write_n;
            for (int d = 0; d < 3; d++) begin
                w  = wmask(d);
                l1 = lvl(d, n - 1);
                l0 = lvl(d, n - 2);
                case (etype(d))
                    0:       det = l1 & ~l0;
                    1:       det = ~l1 & l0;
                    default: det = l1 ^ l0;
                endcase
                det = det & w;
                case (address)
                    2'd0:    e.rd[d] = l1;
                    2'd2:    e.rd[d] = m_mask[d];
                    2'd3:    e.rd[d] = m_cap[d];
                    default: e.rd[d] = 32'd0;
                endcase
                clr = (wr_s && address == 2'd3) ? (writedata & w) : 32'd0;
                if (wr_s && address == 2'd2) m_mask[d] = writedata & w;
                m_cap[d] = (m_cap[d] & ~clr) | det;
                e.irq[d] = |(m_cap[d] & m_mask[d]);
            end
        end
        exp_q.push_back(e);
    end

    // Monitor: pops one expectation per clock and compares the outputs.
    always @(negedge clk) begin : monitor
        exp_t me;
        if (exp_q.size() > 0) begin
            me = exp_q.pop_front();
            for (int d = 0; d < 3; d++) begin
                chk($sformatf("readdata[%0d]", d), rd_a[d], me.rd[d]);
                chk($sformatf("irq[%0d]", d), {31'd0, irq_a[d]}, {31'd0, me.irq[d]});
            end
        end
    end

    task automatic cyc(input logic cs, input logic wn, input logic [1:0] a, input logic [31:0] wd);
        chipselect = cs;
        write_n    = wn;
        address    = a;
        writedata  = wd;
        @(negedge clk);
    endtask

    task automatic rd(input logic [1:0] a, input int n);
        repeat (n) cyc(1'b1, 1'b1, a, 32'd0);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        cyc(1'b1, 1'b0, a, d);
    endtask

    initial begin
        reset_n    = 1'b0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 2'd0;
        writedata  = 32'd0;
        in_port    = 32'd0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // Level path
        rd(2'd0, 1);
        in_port = 32'h0000_00A5;
        rd(2'd0, 6);

        // Rising edge on bit 0 with mask, then clear
        wr(2'd3, 32'hFFFF_FFFF);
        in_port = 32'd0;
        rd(2'd0, 6);
        wr(2'd3, 32'hFFFF_FFFF);
        wr(2'd2, 32'h0000_0001);
        in_port = 32'h0000_0001;
        rd(2'd3, 6);
        wr(2'd3, 32'h0000_0001);
        rd(2'd3, 2);

        // Masked edge on bit 3, mask enabled afterwards
        wr(2'd2, 32'd0);
        in_port = 32'h0000_0009;
        rd(2'd3, 6);
        wr(2'd2, 32'h0000_0008);
        rd(2'd3, 2);

        // Clear colliding with a new edge on bit 2, then clear bit 5 alone
        in_port = 32'h0000_002D;
        rd(2'd3, 2);
        wr(2'd3, 32'h0000_0004);
        rd(2'd3, 4);
        wr(2'd3, 32'h0000_0020);
        rd(2'd3, 2);

        // Falling then rising edges on wide ports, reserved address
        in_port = 32'hFFFF_0000;
        rd(2'd3, 7);
        wr(2'd3, 32'hFFFF_FFFF);
        in_port = 32'h0000_FFFF;
        rd(2'd3, 7);
        rd(2'd1, 2);
        wr(2'd1, 32'hFFFF_FFFF);
        wr(2'd0, 32'hFFFF_FFFF);
        rd(2'd1, 1);
        rd(2'd0, 1);

        // Asynchronous reset while interrupts are pending
        in_port = 32'd0;
        rd(2'd0, 6);
        wr(2'd3, 32'hFFFF_FFFF);
        wr(2'd2, 32'h0000_00FF);
        in_port = 32'h0000_00FF;
        rd(2'd3, 6);
        #2 reset_n = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("async_rst_readdata[%0d]", d), rd_a[d], 32'd0);
            chk($sformatf("async_rst_irq[%0d]", d), {31'd0, irq_a[d]}, 32'd0);
        end
        @(negedge clk);
        reset_n = 1'b1;
        rd(2'd3, 8);

        // Randomised traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(3, 0) == 0) in_port = in_port ^ ($urandom() & $urandom());
            case ($urandom_range(7, 0))
                0:       wr(2'd2, $urandom());
                1, 2:    wr(2'd3, $urandom() & $urandom());
                3:       cyc(1'b0, 1'($urandom_range(1, 0)), 2'($urandom_range(3, 0)), $urandom());
                default: rd(2'($urandom_range(3, 0)), 1);
            endcase
        end
        rd(2'd0, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
